// File: rtl/channel_out.sv
// channel_out: per-channel WS281x (NeoPixel) waveform encoder.
//
// A start pulse makes the block read chan_len+1 LED words from the color
// RAM and send each one as 24 bits, MSB first. Every bit is a high phase
// followed by a low phase. The widths come from the T0H/T0L/T1H/T1L values
// captured at start. After the last bit the line is held low for RST_CYC
// cycles, and then done_o pulses for one cycle.
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous active-high reset
//   start_i         one-cycle start pulse, only accepted while idle
//   reg_t0h_i       T0H in clock cycles (0 behaves as 1)
//   reg_t0l_i       T0L in clock cycles (0 behaves as 1)
//   reg_t1h_i       T1H in clock cycles (0 behaves as 1)
//   reg_t1l_i       T1L in clock cycles (0 behaves as 1)
//   reg_chan_len_i  number of LEDs minus 1
//   ram_rd_en_o     RAM read strobe
//   ram_rd_addr_o   RAM word address (LED index)
//   ram_rd_data_i   RAM read data, valid the cycle after the strobe; [23:0] GRB
//   bit_o           serial LED data line, driven from a flop
//   busy_o          high while a frame is in progress
//   done_o          one-cycle pulse on the last cycle of the latch gap
module channel_out #(
  parameter int RST_CYC = 28000,
  parameter int ADDR_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        reg_t0h_i,
  input  logic [7:0]        reg_t0l_i,
  input  logic [7:0]        reg_t1h_i,
  input  logic [7:0]        reg_t1l_i,
  input  logic [7:0]        reg_chan_len_i,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [31:0]       ram_rd_data_i,
  output logic              bit_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int GAP_W = ($clog2(RST_CYC + 1) < 15) ? 15 : $clog2(RST_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          t0h_q, t0h_d;
  logic [7:0]          t0l_q, t0l_d;
  logic [7:0]          t1h_q, t1h_d;
  logic [7:0]          t1l_q, t1l_d;
  logic [7:0]          len_q, len_d;
  logic [23:0]         shift_q, shift_d;
  logic [23:0]         nxt_q, nxt_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          led_rem_q, led_rem_d;
  logic [7:0]          dur_q, dur_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                bit_q, bit_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  // The upper RAM byte carries no pixel data.
  logic unused_data_hi;
  assign unused_data_hi = ^ram_rd_data_i[31:24];

  // A phase counter is loaded with its length minus one. A programmed 0
  // therefore gives the same 1-cycle phase as a programmed 1.
  function automatic logic [7:0] eff_m1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  // State and datapath registers. Reset clears everything, so an aborted
  // frame drops the line low at once and never produces done_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      t0h_q     <= '0;
      t0l_q     <= '0;
      t1h_q     <= '0;
      t1l_q     <= '0;
      len_q     <= '0;
      shift_q   <= '0;
      nxt_q     <= '0;
      bit_cnt_q <= '0;
      led_rem_q <= '0;
      dur_q     <= '0;
      gap_q     <= '0;
      bit_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      t0h_q     <= t0h_d;
      t0l_q     <= t0l_d;
      t1h_q     <= t1h_d;
      t1l_q     <= t1l_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      nxt_q     <= nxt_d;
      bit_cnt_q <= bit_cnt_d;
      led_rem_q <= led_rem_d;
      dur_q     <= dur_d;
      gap_q     <= gap_d;
      bit_q     <= bit_d;
      rd_en_q   <= rd_en_d;
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
    end
  end

  // Next-state logic. The read strobe is registered. Any state that needs a
  // read issues it for the following cycle, and rd_pend marks the cycle in
  // which that read's data is on the bus.
  always_comb begin
    state_d   = state_q;
    t0h_d     = t0h_q;
    t0l_d     = t0l_q;
    t1h_d     = t1h_q;
    t1l_d     = t1l_q;
    len_d     = len_q;
    shift_d   = shift_q;
    nxt_d     = nxt_q;
    bit_cnt_d = bit_cnt_q;
    led_rem_d = led_rem_q;
    dur_d     = dur_q;
    gap_d     = gap_q;
    bit_d     = bit_q;
    rd_en_d   = 1'b0;
    rd_pend_d = rd_en_q;
    addr_d    = addr_q;

    // Every returned word lands in the next-word buffer. The word-0 capture
    // during WAIT is harmless: the prefetch of word 1 overwrites it before
    // the buffer is ever read.
    if (rd_pend_q) begin
      nxt_d = ram_rd_data_i[23:0];
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          t0h_d   = reg_t0h_i;
          t0l_d   = reg_t0l_i;
          t1h_d   = reg_t1h_i;
          t1l_d   = reg_t1l_i;
          len_d   = reg_chan_len_i;
          rd_en_d = 1'b1;
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end

      // The read of word 0 is on the bus this cycle. Set up the prefetch of
      // word 1 so that it appears while WAIT is active.
      S_FETCH: begin
        if (len_q != 8'd0) begin
          rd_en_d = 1'b1;
          addr_d  = ADDR_W'(1);
        end
        state_d = S_WAIT;
      end

      S_WAIT: begin
        shift_d   = ram_rd_data_i[23:0];
        bit_cnt_d = 5'd23;
        led_rem_d = len_q;
        bit_d     = 1'b1;
        dur_d     = eff_m1(ram_rd_data_i[23] ? t1h_q : t0h_q);
        state_d   = S_HIGH;
      end

      S_HIGH: begin
        if (dur_q == 8'd0) begin
          bit_d   = 1'b0;
          dur_d   = eff_m1(shift_q[23] ? t1l_q : t0l_q);
          state_d = S_LOW;
        end else begin
          dur_d = dur_q - 8'd1;
        end
      end

      // At the end of each low phase, move on to the next bit, then the next
      // LED, then the latch gap. The high phase of the next bit follows with
      // no idle cycle in between.
      S_LOW: begin
        if (dur_q != 8'd0) begin
          dur_d = dur_q - 8'd1;
        end else if (bit_cnt_q != 5'd0) begin
          shift_d   = {shift_q[22:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 5'd1;
          bit_d     = 1'b1;
          dur_d     = eff_m1(shift_q[22] ? t1h_q : t0h_q);
          state_d   = S_HIGH;
        end else if (led_rem_q != 8'd0) begin
          shift_d   = nxt_q;
          bit_cnt_d = 5'd23;
          led_rem_d = led_rem_q - 8'd1;
          bit_d     = 1'b1;
          dur_d     = eff_m1(nxt_q[23] ? t1h_q : t0h_q);
          state_d   = S_HIGH;
          if (led_rem_q > 8'd1) begin
            rd_en_d = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
          end
        end else begin
          gap_d   = GAP_W'(RST_CYC - 1);
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ram_rd_en_o   = rd_en_q;
  assign ram_rd_addr_o = addr_q;
  assign bit_o         = bit_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_GAP) && (gap_q == '0);

endmodule

// File: tb/tb_channel_out.sv
// tb_channel_out: directed testbench for channel_out.
// It models a synchronous color RAM and records RAM reads, done pulses and
// the high/low widths on bit_o. Expected values come from hand-chosen
// vectors and the bit-timing rules.
module tb_channel_out;

  localparam int RST_CYC = 40;
  localparam int ADDR_W  = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [7:0]        reg_t0h_i, reg_t0l_i, reg_t1h_i, reg_t1l_i, reg_chan_len_i;
  logic              ram_rd_en_o;
  logic [ADDR_W-1:0] ram_rd_addr_o;
  logic [31:0]       ram_rd_data_i;
  logic              bit_o, busy_o, done_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  channel_out #(.RST_CYC(RST_CYC), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .reg_t0h_i      (reg_t0h_i),
    .reg_t0l_i      (reg_t0l_i),
    .reg_t1h_i      (reg_t1h_i),
    .reg_t1l_i      (reg_t1l_i),
    .reg_chan_len_i (reg_chan_len_i),
    .ram_rd_en_o    (ram_rd_en_o),
    .ram_rd_addr_o  (ram_rd_addr_o),
    .ram_rd_data_i  (ram_rd_data_i),
    .bit_o          (bit_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  // Synchronous color RAM: data appears the cycle after the read strobe.
  logic [31:0] mem [0:255];
  always @(posedge clk_i) begin
    if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
  end

  // Records RAM reads, done pulses and bit_o run lengths on the falling edge.
  logic monClear;
  int   rdCnt, pulseCnt, runLen, doneCnt;
  logic prevBit;
  logic [7:0] rdLog [0:255];
  int   hiLog [0:2047];
  int   loLog [0:2047];
  always @(negedge clk_i) begin
    if (monClear) begin
      rdCnt = 0; pulseCnt = 0; runLen = 0; doneCnt = 0; prevBit = 1'b0;
    end else begin
      if (ram_rd_en_o === 1'b1) begin
        if (rdCnt < 256) rdLog[rdCnt] = ram_rd_addr_o;
        rdCnt++;
      end
      if (done_o === 1'b1) doneCnt++;
      if (bit_o === prevBit) runLen++;
      else begin
        if (prevBit) begin
          if (pulseCnt < 2048) hiLog[pulseCnt] = runLen;
          pulseCnt++;
        end else if (pulseCnt > 0 && pulseCnt <= 2048) begin
          loLog[pulseCnt-1] = runLen;
        end
        runLen  = 1;
        prevBit = bit_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Programs the timing registers, pulses start_i in cycle 0 and clears the
  // monitors. The task returns in cycle 1.
  task automatic applyStimulus(input int t0h, input int t0l, input int t1h,
                               input int t1l, input int len);
    reg_t0h_i = 8'(t0h); reg_t0l_i = 8'(t0l);
    reg_t1h_i = 8'(t1h); reg_t1l_i = 8'(t1l);
    reg_chan_len_i = 8'(len);
    start_i = 1'b1; monClear = 1'b1;
    tick();
    start_i = 1'b0; monClear = 1'b0;
  endtask

  // Waits, with a cycle budget, until done_o is high; doneAt is the cycle number.
  task automatic waitDone(input int startRel, input int budget, output int doneAt);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    doneAt = startRel + n;
    checkOutput("doneSeen", done_o, 1);
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int frameLen(input int nLeds, input int t0h, input int t0l,
                                  input int t1h, input int t1l);
    int s = 2 + RST_CYC;
    for (int i = 0; i < nLeds; i++)
      for (int b = 23; b >= 0; b--)
        s += mem[i][b] ? (eff(t1h) + eff(t1l)) : (eff(t0h) + eff(t0l));
    return s;
  endfunction

  // Compares the recorded pulse count, high widths and inner low widths.
  task automatic checkPulses(input string tag, input int nLeds, input int t0h,
                             input int t0l, input int t1h, input int t1l);
    int total = nLeds * 24;
    checkOutput({tag, " pulses"}, pulseCnt, total);
    for (int i = 0; i < nLeds; i++)
      for (int b = 23; b >= 0; b--) begin
        int idx = i * 24 + (23 - b);
        logic v = mem[i][b];
        checkOutput($sformatf("%s hi[%0d]", tag, idx), hiLog[idx], v ? eff(t1h) : eff(t0h));
        if (idx < total - 1)
          checkOutput($sformatf("%s lo[%0d]", tag, idx), loLog[idx], v ? eff(t1l) : eff(t0l));
      end
  endtask

  task automatic checkReads(input string tag, input int n);
    checkOutput({tag, " reads"}, rdCnt, n);
    for (int i = 0; i < n && i < 256; i++)
      checkOutput($sformatf("%s addr[%0d]", tag, i), rdLog[i], i);
  endtask

  initial begin
    int doneAt;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_i = 1'b1; start_i = 1'b0; monClear = 1'b1;
    reg_t0h_i = 8'd0; reg_t0l_i = 8'd0; reg_t1h_i = 8'd0; reg_t1l_i = 8'd0;
    reg_chan_len_i = 8'd0;

    // Reset held with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      start_i = ~start_i; reg_t1h_i = 8'(i * 37); reg_chan_len_i = 8'(i);
      tick();
      checkOutput("rst bit", bit_o, 0);
      checkOutput("rst busy", busy_o, 0);
      checkOutput("rst done", done_o, 0);
      checkOutput("rst rden", ram_rd_en_o, 0);
      checkOutput("rst addr", ram_rd_addr_o, 0);
    end
    start_i = 1'b0;
    rst_i = 1'b0;
    tick();
    monClear = 1'b0;
    tick();

    // Frame 1: single LED. A start mid-frame and a start on the done cycle are both ignored.
    mem[0] = 32'h00A5_0F3C;
    applyStimulus(3, 8, 6, 5, 0);
    checkOutput("f1 c1 rden", ram_rd_en_o, 1);
    checkOutput("f1 c1 addr", ram_rd_addr_o, 0);
    checkOutput("f1 c1 busy", busy_o, 1);
    tick();
    checkOutput("f1 c2 bit", bit_o, 0);
    checkOutput("f1 c2 rden", ram_rd_en_o, 0);
    tick();
    checkOutput("f1 c3 bit", bit_o, 1);
    for (int i = 3; i < 20; i++) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    waitDone(21, 2000, doneAt);
    checkOutput("f1 length", doneAt, frameLen(1, 3, 8, 6, 5));
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checkOutput("f1 post busy", busy_o, 0);
    checkOutput("f1 post done", done_o, 0);
    checkOutput("f1 doneCnt", doneCnt, 1);
    checkReads("f1", 1);
    checkPulses("f1", 1, 3, 8, 6, 5);

    // Frame 2: all timings zero, two LEDs, started on the cycle after done.
    mem[0] = 32'h0012_3456;
    mem[1] = 32'hFFAB_CDEF;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("f2 c1 rden", ram_rd_en_o, 1);
    checkOutput("f2 c1 busy", busy_o, 1);
    tick();
    checkOutput("f2 c2 prefetch", ram_rd_en_o, 1);
    checkOutput("f2 c2 addr", ram_rd_addr_o, 1);
    waitDone(2, 2000, doneAt);
    checkOutput("f2 length", doneAt, frameLen(2, 0, 0, 0, 0));
    tick();
    checkOutput("f2 post busy", busy_o, 0);
    checkReads("f2", 2);
    checkPulses("f2", 2, 0, 0, 0, 0);

    // Frame 3: t1h and chan_len change after start; the latched values apply.
    mem[0] = 32'h00F0_F0F0;
    mem[1] = 32'h000F_F00F;
    applyStimulus(2, 3, 4, 2, 1);
    for (int i = 1; i < 5; i++) tick();
    reg_t1h_i = 8'd9;
    reg_chan_len_i = 8'd0;
    waitDone(5, 2000, doneAt);
    checkOutput("f3 length", doneAt, frameLen(2, 2, 3, 4, 2));
    tick();
    checkReads("f3", 2);
    checkPulses("f3", 2, 2, 3, 4, 2);

    // Frame 4: the new values now apply.
    applyStimulus(2, 3, 9, 2, 0);
    waitDone(1, 2000, doneAt);
    checkOutput("f4 length", doneAt, frameLen(1, 2, 3, 9, 2));
    tick();
    checkReads("f4", 1);
    checkPulses("f4", 1, 2, 3, 9, 2);

    // Frame 5: 64 LEDs, RAM[i] = i * 0x010203.
    for (int i = 0; i < 64; i++) mem[i] = i * 32'h0001_0203;
    applyStimulus(3, 5, 5, 3, 63);
    waitDone(1, 20000, doneAt);
    checkOutput("f64 length", doneAt, frameLen(64, 3, 5, 5, 3));
    tick();
    checkOutput("f64 doneCnt", doneCnt, 1);
    checkReads("f64", 64);
    checkPulses("f64", 64, 3, 5, 5, 3);

    // Reset in the middle of a bit: the line drops at once and no done follows.
    mem[0] = 32'h00A5_0F3C;
    applyStimulus(3, 8, 6, 5, 0);
    tick();
    tick();
    tick();
    checkOutput("abort bit high", bit_o, 1);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("abort bit async", bit_o, 0);
    checkOutput("abort busy async", busy_o, 0);
    for (int i = 0; i < 3; i++) begin
      start_i = ~start_i;
      tick();
      checkOutput("abort hold bit", bit_o, 0);
    end
    start_i = 1'b0;
    rst_i = 1'b0;
    for (int i = 0; i < 400; i++) tick();
    checkOutput("abort doneCnt", doneCnt, 0);
    checkOutput("abort idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/channel_out.md
Name: channel_out

Overview:
- Per-channel NeoPixel (WS281x) waveform encoder. Sits directly downstream of channel_ctl and its color RAM.
- On a start pulse (channel_ctl's ram_wr_done), it reads the LED words of one channel from the color RAM and serialises each as 24 bits, MSB first, using the programmed T0H/T0L/T1H/T1L timing.
- After the last bit it holds the line low for the latch/reset gap, then reports done.
- One instance per output channel.

Parameters:
- RST_CYC, 28000: latch gap length in clock cycles (280 us at 100 MHz).
- ADDR_W, 8: RAM word address width.

Ports:
- clk_i  in  1  system clock (100 MHz, 10 ns per timing unit)
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle pulse; begin frame transmission
- reg_t0h_i  in  8  T0H in clock cycles
- reg_t0l_i  in  8  T0L in clock cycles
- reg_t1h_i  in  8  T1H in clock cycles
- reg_t1l_i  in  8  T1L in clock cycles
- reg_chan_len_i  in  8  number of LEDs minus 1
- ram_rd_en_o  out  1  RAM read strobe
- ram_rd_addr_o  out  ADDR_W  RAM word address (LED index)
- ram_rd_data_i  in  32  RAM data; [23:0] = GRB, valid the cycle after ram_rd_en_o; [31:24] ignored
- bit_o  out  1  serial LED data line
- busy_o  out  1  high from the cycle after an accepted start_i until done_o
- done_o  out  1  one-cycle pulse at the end of the latch gap

Behaviour:
- Reset (async, rst_i=1): state IDLE; bit_o=0, busy_o=0, done_o=0, ram_rd_en_o=0, ram_rd_addr_o=0. All counters and buffers are cleared.
- Reset mid-frame aborts immediately: bit_o drops low asynchronously. No done_o is produced.
- start_i is accepted only in IDLE. When accepted, the block latches reg_t0h_i/t0l/t1h/t1l and reg_chan_len_i; the latched copies are used for the whole frame. start_i while busy is ignored.
- A programmed timing value of 0 is treated as 1 cycle.
- States: IDLE -> FETCH -> WAIT -> HIGH <-> LOW -> GAP -> IDLE.
- FETCH (1 cycle): ram_rd_en_o=1, ram_rd_addr_o=0.
- WAIT (1 cycle): ram_rd_data_i[23:0] is loaded into the 24-bit shift register and bit counter=23. In the same cycle the prefetch of address 1 is issued if chan_len>0.
- HIGH: bit_o=1 for THx cycles, where x = shift_reg[23]. Then go to LOW.
- LOW: bit_o=0 for TLx cycles. At the end of LOW:
  - if bits remain, shift left by 1, decrement the bit counter, go to HIGH;
  - else if LEDs remain, load the prefetched word, bit counter=23, and issue the prefetch for the next address (if any); go to HIGH with no inter-LED gap;
  - else go to GAP.
- Prefetch: ram_rd_en_o is pulsed for exactly one cycle per LED word after the first. Data is captured into a 24-bit next-word buffer the following cycle. Since the minimum bit length is 2 cycles, the buffer is always valid before it is needed.
- Address sequence is 0..chan_len, wrapping is impossible (8-bit). Exactly chan_len+1 reads occur per frame.
- GAP: bit_o=0 for RST_CYC cycles. done_o=1 on the last GAP cycle; busy_o falls on the next cycle (back in IDLE).
- Timing: start_i sampled at cycle 0; FETCH in cycle 1; WAIT in cycle 2; bit_o rises at cycle 3 (registered output). A start_i in the same cycle done_o is asserted is ignored; start_i in the following IDLE cycle is accepted.
- Duration counters are 8-bit; the GAP counter is 15-bit minimum, sized for RST_CYC.
- bit_o is glitch-free (driven from a flop).

Test Plan:
- Reset: hold rst_i=1 with toggling inputs -> bit_o, busy_o, done_o, ram_rd_en_o all 0. Assert rst_i mid-bit -> bit_o=0 immediately and no done_o.
- Single LED: t0h=0x01→treated as 1? Use t0h=3, t0l=8, t1h=6, t1l=5, chan_len=0, word 0x00A5_0F3C. Required response:
  - first rise at cycle 3;
  - 24 pulses with high widths 3/6 following 0xA50F3C MSB first;
  - exactly 1 RAM read;
  - GAP of RST_CYC cycles, then done_o pulse.
- 64 LEDs: chan_len=0x3f, RAM[i]=i*0x010203 -> 64 reads at addresses 0..63 in order. Each read is one cycle. Periods are exactly THx+TLx with no extra cycles between LEDs. Total frame length = sum of bit periods + 2 + RST_CYC.
- Timing zero: t0h=0, t0l=0, t1h=0, t1l=0, chan_len=1 -> every bit is 1 high + 1 low cycle. Prefetch still lands in time and both LEDs are encoded correctly.
- Start during busy: second start_i mid-frame, and a start_i coincident with done_o -> both ignored. Start on the cycle after done_o -> new frame begins with FETCH at the next cycle.
- Register change mid-frame: alter reg_t1h_i and reg_chan_len_i after start -> the frame uses the values latched at start. The next frame uses the new values.
